register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 64-bit general register file for the 64-bit pipelined CPU.
- Receiving end of the write-back interface: consumes the write-back stage's destination register, write data and write enable.
- Supplies the two source operands to the decode/register-read stage through registered read ports with write-through forwarding.
- X31 is the hard-wired zero register (XZR).

Parameters:
- DATA_W, 64, register and data width.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; log2(NUM_REGS).
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Reg2Write  input  ADDR_W  destination register from write-back.
- Data2Write  input  DATA_W  write data from write-back.
- RegWrite  input  1  write enable from write-back.
- ReadReg1  input  ADDR_W  source register index, port 1.
- ReadReg2  input  ADDR_W  source register index, port 2.
- Stall  input  1  holds both read outputs (pipeline freeze).
- ReadData1  output  DATA_W  registered operand, port 1.
- ReadData2  output  DATA_W  registered operand, port 2.
- WriteCount  output  16  number of committed writes, for debug.

Behaviour:
- Reset:
  - reset high forces all 32 registers, ReadData1, ReadData2 and WriteCount to 0 immediately, without waiting for a clock edge.
  - State stays 0 while reset is held.
  - On the first rising edge after deassertion, normal operation resumes.
  - Reset asserted mid-write discards that write.
- Write:
  - A write commits on a rising edge when RegWrite==1 and Reg2Write!=ZERO_REG: regs[Reg2Write] <= Data2Write.
  - A write with Reg2Write==ZERO_REG is dropped. WriteCount does not increment for it.
  - WriteCount increments by 1 per committed write and wraps 0xFFFF -> 0x0000.
  - Writes commit regardless of Stall.
- Read (latency 1 cycle):
  - On each rising edge with Stall==0, ReadDataN <= value(ReadRegN).
  - With Stall==1, ReadData1 and ReadData2 hold their previous values. Writes still commit.
- value(r), in priority order:
  1. r==ZERO_REG -> 0.
  2. If a write to r commits on the same edge (RegWrite==1 and Reg2Write==r), return Data2Write (write-through forwarding; the read never returns stale data).
  3. Otherwise regs[r].
- Both ports may read the same register; both return the same value.
- Reads of the same register in consecutive cycles reflect the write committed on the earlier edge.
- Widths:
  - Indices are ADDR_W bits; every encodable index is valid.
  - No arithmetic is performed on data; values are stored verbatim, all 64 bits.
- No internal state machine beyond storage, the read registers and the counter. No X may propagate to outputs after reset.

Test Plan:
- Reset: load X5=0x1234, assert reset asynchronously between edges -> ReadData1/2=0 and WriteCount=0 immediately; reading X5 after deassertion returns 0.
- Write then read:
  - Stimulus: RegWrite=1, Reg2Write=3, Data2Write=0xDEADBEEF_CAFEF00D; next cycle ReadReg1=3.
  - Required: ReadData1=0xDEADBEEFCAFEF00D one edge later; WriteCount=1.
- Forwarding: same edge writes X7=0xAAAA_5555_AAAA_5555 while ReadReg1=ReadReg2=7 -> both outputs=0xAAAA5555AAAA5555 after that edge (old X7=0 never appears).
- XZR: write X31=0xFFFF_FFFF_FFFF_FFFF, then read X31 on both ports -> 0, also on the same-edge case; WriteCount unchanged.
- Stall:
  - Stimulus: ReadData1=X2=0x10; assert Stall, write X2=0x20 and set ReadReg1=4 (X4=0x40).
  - Required: ReadData1 stays 0x10 while stalled; after Stall drops, ReadReg1=2 yields 0x20.
- Counter wrap: perform 65537 committed writes -> WriteCount=0x0001; interleaved writes to X31 are not counted.

Source files
------------

// File: rtl/register_file_if.sv
// Write-back / register-read bundle between the pipeline and the register file.
// Pure wiring, no state, so it adds no latency.
// There is no backpressure; Stall is the only hold control and it freezes the read outputs.
interface register_file_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] Reg2Write;
   logic [DATA_W-1:0] Data2Write;
   logic              RegWrite;
   logic [ADDR_W-1:0] ReadReg1;
   logic [ADDR_W-1:0] ReadReg2;
   logic              Stall;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;
   logic [15:0]       WriteCount;

   // Pipeline side: drives write-back and read requests, receives the operands.
   modport master (
      output Reg2Write, Data2Write, RegWrite, ReadReg1, ReadReg2, Stall,
      input  ReadData1, ReadData2, WriteCount
   );

   // Register-file side.
   modport slave (
      input  Reg2Write, Data2Write, RegWrite, ReadReg1, ReadReg2, Stall,
      output ReadData1, ReadData2, WriteCount
   );
endinterface

// File: rtl/register_file.sv
// 32 x 64-bit register file with XZR, two registered read ports and write-through forwarding.
// Read data appears 1 cycle after the index is presented; writes commit on the same edge.
// No backpressure: Stall holds both read outputs while writes keep committing.
module register_file #(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input logic            clk,
   input logic            reset,
   register_file_if.slave rf
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd1_q;
   logic [DATA_W-1:0] rd2_q;
   logic [DATA_W-1:0] rd1_nxt;
   logic [DATA_W-1:0] rd2_nxt;
   logic [15:0]       cnt_q;
   logic              commit;

   // A write to XZR is dropped entirely: no storage update, no count.
   assign commit = rf.RegWrite && (rf.Reg2Write != ZERO_IDX);

   // Operand selection: XZR reads zero, a same-edge write is forwarded so a read never sees stale data.
   always_comb begin
      rd1_nxt = regs[rf.ReadReg1];
      rd2_nxt = regs[rf.ReadReg2];
      if (rf.ReadReg1 == ZERO_IDX) begin
         rd1_nxt = '0;
      end else if (commit && (rf.Reg2Write == rf.ReadReg1)) begin
         rd1_nxt = rf.Data2Write;
      end
      if (rf.ReadReg2 == ZERO_IDX) begin
         rd2_nxt = '0;
      end else if (commit && (rf.Reg2Write == rf.ReadReg2)) begin
         rd2_nxt = rf.Data2Write;
      end
   end

   // Architectural storage; the XZR entry is never written so it stays zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[rf.Reg2Write] <= rf.Data2Write;
      end
   end

   // Read-port registers (held under Stall) and the committed-write counter (wraps naturally at 16 bits).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd1_q <= '0;
         rd2_q <= '0;
         cnt_q <= '0;
      end else begin
         if (!rf.Stall) begin
            rd1_q <= rd1_nxt;
            rd2_q <= rd2_nxt;
         end
         if (commit) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign rf.ReadData1  = rd1_q;
   assign rf.ReadData2  = rd2_q;
   assign rf.WriteCount = cnt_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected outputs, a monitor pops and compares.
// Expected values come from an array-based model of the architectural registers.
// Runs directed cases, a randomized phase, a mid-cycle reset and a counter wrap.
module tb_register_file;

   typedef struct {
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   register_file_if #(.DATA_W(64), .ADDR_W(5)) bus ();

   register_file dut (
      .clk   (clk),
      .reset (reset),
      .rf    (bus)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] mregs [32];
   logic [63:0] mrd1;
   logic [63:0] mrd2;
   logic [15:0] mcnt;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      mrd1 = 64'd0;
      mrd2 = 64'd0;
      mcnt = 16'd0;
   endtask

   function automatic logic [63:0] model_val(input logic [4:0] r, input logic we,
                                              input logic [4:0] wa, input logic [63:0] wd);
      if (r == 5'd31) return 64'd0;
      if (we && wa == r) return wd;
      return mregs[r];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // One clock of stimulus; the expected post-edge outputs are queued for the monitor.
   task automatic cyc(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic st);
      exp_t        e;
      logic [63:0] v1;
      logic [63:0] v2;
      @(negedge clk);
      bus.RegWrite   = we;
      bus.Reg2Write  = wa;
      bus.Data2Write = wd;
      bus.ReadReg1   = r1;
      bus.ReadReg2   = r2;
      bus.Stall      = st;
      v1 = model_val(r1, we, wa, wd);
      v2 = model_val(r2, we, wa, wd);
      if (we && wa != 5'd31) begin
         mregs[wa] = wd;
         mcnt      = mcnt + 16'd1;
      end
      if (!st) begin
         mrd1 = v1;
         mrd2 = v2;
      end
      e.rd1 = mrd1;
      e.rd2 = mrd2;
      e.cnt = mcnt;
      q.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle outside reset, so one expectation is consumed per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.ReadData1 !== e.rd1 || bus.ReadData2 !== e.rd2 || bus.WriteCount !== e.cnt) begin
               n_bad++;
               $display("FAIL scoreboard @%0t: got rd1=%h rd2=%h cnt=%h, expected rd1=%h rd2=%h cnt=%h",
                        $time, bus.ReadData1, bus.ReadData2, bus.WriteCount, e.rd1, e.rd2, e.cnt);
            end
         end
      end
   end

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 9) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      int n;
      reset          = 1'b1;
      bus.RegWrite   = 1'b0;
      bus.Reg2Write  = '0;
      bus.Data2Write = '0;
      bus.ReadReg1   = '0;
      bus.ReadReg2   = '0;
      bus.Stall      = 1'b0;
      model_clear();
      #1;
      check("reset_rd1", bus.ReadData1, 64'd0);
      check("reset_rd2", bus.ReadData2, 64'd0);
      check("reset_cnt", {48'd0, bus.WriteCount}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Write then read one edge later.
      cyc(1'b1, 5'd3, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 64'd0, 5'd3, 5'd3, 1'b0);
      // Same-edge forwarding to both ports.
      cyc(1'b1, 5'd7, 64'hAAAA5555_AAAA5555, 5'd7, 5'd7, 1'b0);
      cyc(1'b0, 5'd0, 64'd0, 5'd7, 5'd3, 1'b0);
      // XZR: dropped write, reads zero, including the same-edge case.
      cyc(1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 5'd31, 5'd31, 1'b0);
      cyc(1'b0, 5'd0, 64'd0, 5'd31, 5'd31, 1'b0);
      // Stall holds outputs while writes commit.
      cyc(1'b1, 5'd2, 64'h10, 5'd2, 5'd7, 1'b0);
      cyc(1'b1, 5'd4, 64'h40, 5'd2, 5'd7, 1'b0);
      cyc(1'b1, 5'd2, 64'h20, 5'd4, 5'd4, 1'b1);
      cyc(1'b0, 5'd0, 64'd0, 5'd4, 5'd4, 1'b1);
      cyc(1'b0, 5'd0, 64'd0, 5'd2, 5'd4, 1'b0);

      // Randomized traffic on a small register window to hit forwarding often.
      for (int i = 0; i < 500; i++) begin
         cyc(1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom},
             pick_reg(), pick_reg(), ($urandom_range(0, 4) == 0));
      end

      // Mid-cycle asynchronous reset during a pending write.
      cyc(1'b1, 5'd5, 64'h1234, 5'd0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 1'b0);
      @(posedge clk);
      #3;
      bus.RegWrite   = 1'b1;
      bus.Reg2Write  = 5'd5;
      bus.Data2Write = 64'hBAD0BAD0_BAD0BAD0;
      reset          = 1'b1;
      #1;
      check("async_rd1", bus.ReadData1, 64'd0);
      check("async_rd2", bus.ReadData2, 64'd0);
      check("async_cnt", {48'd0, bus.WriteCount}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.RegWrite = 1'b0;
      reset        = 1'b0;
      model_clear();
      cyc(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 1'b0);
      cyc(1'b0, 5'd0, 64'd0, 5'd5, 5'd31, 1'b0);

      // Counter wrap: 65537 committed writes with uncounted XZR writes mixed in.
      n = 0;
      while (n < 65537) begin
         if ($urandom_range(0, 7) == 0) begin
            cyc(1'b1, 5'd31, {$urandom, $urandom}, pick_reg(), pick_reg(), 1'b0);
         end else begin
            cyc(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom},
                pick_reg(), pick_reg(), ($urandom_range(0, 7) == 0));
            n++;
         end
      end
      @(posedge clk);
      #2;
      check("wrap_cnt", {48'd0, bus.WriteCount}, 64'd1);

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
